// File: rtl/mux_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants for the N-to-1 pipelined select.
//               - occupancy state encoding of the 2-entry skid buffer
//               - default data width / input count
//               - error counter width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    // Occupancy states: EMPTY = nothing held, ONE = output register full,
    // TWO = output register and skid register full.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    localparam int c_DEF_SIZE = 32;
    localparam int c_DEF_NUM  = 4;
    localparam int c_ERRCNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry valid/ready skid buffer with registered ready.
//               Ports:
//                 clk, rst_n          clock, asynchronous active-low reset
//                 i_data/i_valid      upstream beat
//                 o_ready             upstream may transfer (registered)
//                 o_data/o_valid      output register contents / occupancy
//                 i_ready             downstream accepts o_data
//                 o_load              output register was loaded at last edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buf2
    import mux_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_load
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;
    logic             r_ready;
    logic             r_load;
    logic             w_in;
    logic             w_out;
    logic             w_load_in;
    logic             w_load_skid;
    logic             w_skid_we;

    assign w_in  = i_valid & r_ready;
    assign w_out = (r_state != c_ST_EMPTY) & i_ready;

    always_comb begin
        w_next      = r_state;
        w_load_in   = 1'b0;
        w_load_skid = 1'b0;
        w_skid_we   = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_in) begin
                    w_next    = c_ST_ONE;
                    w_load_in = 1'b1;
                end
            end
            c_ST_ONE: begin
                if (w_in && !w_out) begin
                    // Downstream stalled: park the new beat behind the output.
                    w_next    = c_ST_TWO;
                    w_skid_we = 1'b1;
                end else if (!w_in && w_out) begin
                    w_next = c_ST_EMPTY;
                end else if (w_in && w_out) begin
                    w_load_in = 1'b1;
                end
            end
            c_ST_TWO: begin
                // No input can arrive here since ready was dropped.
                if (w_out) begin
                    w_next      = c_ST_ONE;
                    w_load_skid = 1'b1;
                end
            end
            default: begin
                w_next = c_ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
            r_ready <= 1'b1;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != c_ST_TWO);
            r_load  <= w_load_in | w_load_skid;
            if (w_load_in) begin
                r_out <= i_data;
            end else if (w_load_skid) begin
                r_out <= r_skid;
            end
            if (w_skid_we) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_out;
    assign o_valid = (r_state != c_ST_EMPTY);
    assign o_load  = r_load;

endmodule

`default_nettype wire

// File: rtl/mux_nto1_pipe.sv
// ============================================================================
// Module      : mux_nto1_pipe
// Description : Parametrised N-to-1 select with registered, valid/ready
//               flow-controlled output (one-cycle latency, 2-entry skid).
//               Out-of-range selects deliver the last in-range value and
//               pulse err_o when that beat first appears on data_o.
//               Optional macro MUX_ERRCNT_EN builds the saturating error
//               counter on err_cnt_o; otherwise err_cnt_o is tied to zero.
//               Ports:
//                 clk_i, rst_i        clock, asynchronous active-low reset
//                 data_i              NUM packed words of SIZE bits
//                 select_i, valid_i   input index and beat valid
//                 ready_o             upstream may transfer (registered)
//                 data_o, valid_o     selected data (registered) / valid
//                 ready_i             downstream accepts data_o
//                 err_o               one-cycle pulse, out-of-range beat
//                 err_cnt_o           out-of-range beat count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int SIZE  = c_DEF_SIZE,
    parameter int NUM   = c_DEF_NUM,
    parameter int SEL_W = $clog2(NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM*SIZE-1:0]   data_i,
    input  logic [SEL_W-1:0]      select_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [SIZE-1:0]       data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o,
    output logic [c_ERRCNT_W-1:0] err_cnt_o
);

    localparam logic [SEL_W:0] c_NUM_EXT = (SEL_W + 1)'(NUM);

    logic [SIZE-1:0] w_word [NUM];
    logic [SIZE-1:0] w_sel_word;
    logic [SIZE-1:0] r_last;
    logic            w_in_range;
    logic            w_accept;
    logic [SIZE:0]   w_beat;
    logic [SIZE:0]   w_out_beat;
    logic            w_load;

    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
        assign w_word[gi] = data_i[gi*SIZE +: SIZE];
    end

    // Compare-and-pick avoids indexing past NUM-1 when NUM is not a power of 2.
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < NUM; k++) begin
            if (select_i == SEL_W'(k)) begin
                w_sel_word = w_word[k];
            end
        end
    end

    assign w_in_range = ({1'b0, select_i} < c_NUM_EXT);
    assign w_accept   = valid_i & ready_o;

    // MSB carries the error flag alongside the data through the buffer.
    assign w_beat = {~w_in_range, (w_in_range ? w_sel_word : r_last)};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last <= '0;
        end else if (w_accept && w_in_range) begin
            r_last <= w_sel_word;
        end
    end

    skid_buf2 #(
        .WIDTH (SIZE + 1)
    ) u_skid (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .i_data  (w_beat),
        .i_valid (valid_i),
        .o_ready (ready_o),
        .o_data  (w_out_beat),
        .o_valid (valid_o),
        .i_ready (ready_i),
        .o_load  (w_load)
    );

    assign data_o = w_out_beat[SIZE-1:0];
    // Only the first cycle a flagged beat sits in the output register counts,
    // so a stalled beat pulses once.
    assign err_o  = w_load & w_out_beat[SIZE];

`ifdef MUX_ERRCNT_EN
    logic [c_ERRCNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err_cnt <= '0;
        end else if (err_o && (r_err_cnt != {c_ERRCNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + c_ERRCNT_W'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_pipe.sv
// ============================================================================
// Module      : tb_mux_nto1_pipe
// Description : Directed self-checking bench for mux_nto1_pipe. Instance A is
//               SIZE=32/NUM=4, instance B is SIZE=32/NUM=5 (out-of-range
//               selects possible). Honours MUX_ERRCNT_EN for counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_pipe;

`ifdef MUX_ERRCNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // Instance A
    logic [127:0] a_data;
    logic [1:0]   a_sel;
    logic         a_valid;
    logic         a_ready_o;
    logic [31:0]  a_dout;
    logic         a_vout;
    logic         a_ready_i;
    logic         a_err;
    logic [7:0]   a_cnt;

    // Instance B
    logic [159:0] b_data;
    logic [2:0]   b_sel;
    logic         b_valid;
    logic         b_ready_o;
    logic [31:0]  b_dout;
    logic         b_vout;
    logic         b_ready_i;
    logic         b_err;
    logic [7:0]   b_cnt;

    int checks;
    int errors;

    mux_nto1_pipe #(.SIZE(32), .NUM(4)) u_dut_a (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .data_i    (a_data),
        .select_i  (a_sel),
        .valid_i   (a_valid),
        .ready_o   (a_ready_o),
        .data_o    (a_dout),
        .valid_o   (a_vout),
        .ready_i   (a_ready_i),
        .err_o     (a_err),
        .err_cnt_o (a_cnt)
    );

    mux_nto1_pipe #(.SIZE(32), .NUM(5)) u_dut_b (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .data_i    (b_data),
        .select_i  (b_sel),
        .valid_i   (b_valid),
        .ready_o   (b_ready_o),
        .data_o    (b_dout),
        .valid_o   (b_vout),
        .ready_i   (b_ready_i),
        .err_o     (b_err),
        .err_cnt_o (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_data = '0; a_sel = '0; a_valid = 1'b0; a_ready_i = 1'b1;
        b_data = '0; b_sel = '0; b_valid = 1'b0; b_ready_i = 1'b1;
        repeat (2) cyc();
        checks++; if (a_dout !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", a_dout); end
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", a_vout); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", a_ready_o); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", b_err); end
        checks++; if (b_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", b_cnt); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_select();
        int exp_w [4] = '{11, 22, 33, 44};
        a_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) a_data[k*32 +: 32] = 32'(exp_w[k]);
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k);
            a_valid = 1'b1;
            cyc();
            checks++; if (a_dout !== 32'(exp_w[k])) begin errors++; $display("FAIL sel%0d_data got %0d exp %0d", k, a_dout, exp_w[k]); end
            checks++; if (a_vout !== 1'b1) begin errors++; $display("FAIL sel%0d_valid got %b exp 1", k, a_vout); end
            checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL sel%0d_ready got %b exp 1", k, a_ready_o); end
        end
        a_valid = 1'b0;
        cyc();
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL sel_drain_valid got %b exp 0", a_vout); end
    endtask

    task automatic test_out_of_range();
        b_ready_i = 1'b1;
        b_data[0*32 +: 32] = 32'h1;
        b_data[1*32 +: 32] = 32'h2;
        b_data[2*32 +: 32] = 32'hA5;
        b_data[3*32 +: 32] = 32'h4;
        b_data[4*32 +: 32] = 32'h55;
        // in-range sel 2
        b_sel = 3'd2; b_valid = 1'b1;
        cyc();
        checks++; if (b_dout !== 32'hA5) begin errors++; $display("FAIL oor_s2_data got %h exp a5", b_dout); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL oor_s2_err got %b exp 0", b_err); end
        // sel 7 holds 0xA5
        b_sel = 3'd7;
        cyc();
        checks++; if (b_dout !== 32'hA5) begin errors++; $display("FAIL oor_s7_data got %h exp a5", b_dout); end
        checks++; if (b_vout !== 1'b1) begin errors++; $display("FAIL oor_s7_valid got %b exp 1", b_vout); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL oor_s7_err got %b exp 1", b_err); end
        // last in-range index
        b_sel = 3'd4;
        cyc();
        checks++; if (b_dout !== 32'h55) begin errors++; $display("FAIL oor_s4_data got %h exp 55", b_dout); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL oor_s4_err got %b exp 0", b_err); end
        checks++; if (b_cnt !== (c_CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL oor_cnt1 got %0d exp %0d", b_cnt, c_CNT_EN ? 1 : 0); end
        // first out-of-range index (== NUM), word 4 changes but hold keeps 0x55
        b_sel = 3'd5;
        b_data[4*32 +: 32] = 32'h77;
        cyc();
        checks++; if (b_dout !== 32'h55) begin errors++; $display("FAIL oor_s5_data got %h exp 55", b_dout); end
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL oor_s5_err got %b exp 1", b_err); end
        b_valid = 1'b0;
        cyc();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL oor_idle_err got %b exp 0", b_err); end
        checks++; if (b_vout !== 1'b0) begin errors++; $display("FAIL oor_idle_valid got %b exp 0", b_vout); end
        checks++; if (b_cnt !== (c_CNT_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL oor_cnt2 got %0d exp %0d", b_cnt, c_CNT_EN ? 2 : 0); end
    endtask

    task automatic test_back_to_back();
        a_ready_i = 1'b0;
        a_data[0*32 +: 32] = 32'h100;
        a_data[1*32 +: 32] = 32'h200;
        a_data[2*32 +: 32] = 32'h300;
        a_sel = 2'd0; a_valid = 1'b1;
        cyc();
        checks++; if (a_dout !== 32'h100) begin errors++; $display("FAIL b2b_1_data got %h exp 100", a_dout); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_1_ready got %b exp 1", a_ready_o); end
        a_sel = 2'd1;
        cyc();
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_2_ready got %b exp 0", a_ready_o); end
        checks++; if (a_dout !== 32'h100) begin errors++; $display("FAIL b2b_2_data got %h exp 100", a_dout); end
        a_sel = 2'd2;
        cyc();
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_3_ready got %b exp 0", a_ready_o); end
        checks++; if (a_dout !== 32'h100 || a_vout !== 1'b1) begin errors++; $display("FAIL b2b_3_stall got %h/%b exp 100/1", a_dout, a_vout); end
        a_valid = 1'b0; a_ready_i = 1'b1;
        cyc();
        checks++; if (a_dout !== 32'h200 || a_vout !== 1'b1) begin errors++; $display("FAIL b2b_drain_data got %h/%b exp 200/1", a_dout, a_vout); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_drain_ready got %b exp 1", a_ready_o); end
        cyc();
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL b2b_empty_valid got %b exp 0", a_vout); end
    endtask

    task automatic test_async_reset();
        a_ready_i = 1'b0;
        a_data[0*32 +: 32] = 32'hDEAD;
        a_data[1*32 +: 32] = 32'hBEEF;
        a_sel = 2'd0; a_valid = 1'b1;
        cyc();
        a_sel = 2'd1;
        cyc();
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL ar_two_ready got %b exp 0", a_ready_o); end
        #2;
        rst_n = 1'b0;
        a_valid = 1'b0;
        #1;
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", a_vout); end
        checks++; if (a_dout !== 32'd0) begin errors++; $display("FAIL ar_data got %h exp 0", a_dout); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", a_ready_o); end
        checks++; if (b_cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", b_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        a_ready_i = 1'b1;
        cyc();
        checks++; if (a_vout !== 1'b0) begin errors++; $display("FAIL ar_post_valid got %b exp 0", a_vout); end
    endtask

    task automatic test_errcnt_sat();
        b_ready_i = 1'b1;
        b_sel = 3'd7; b_valid = 1'b1;
        repeat (255) cyc();
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL sat_err got %b exp 1", b_err); end
        checks++; if (b_cnt !== (c_CNT_EN ? 8'd254 : 8'd0)) begin errors++; $display("FAIL sat_cnt254 got %0d exp %0d", b_cnt, c_CNT_EN ? 254 : 0); end
        repeat (45) cyc();
        b_valid = 1'b0;
        repeat (2) cyc();
        checks++; if (b_cnt !== (c_CNT_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt255 got %0d exp %0d", b_cnt, c_CNT_EN ? 255 : 0); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL sat_idle_err got %b exp 0", b_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_select();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        test_errcnt_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
